// File: rtl/acia_rx_framer.sv
// Asynchronous receive framer replacing the 6850 receive path: synchronises RxC/RxD/DCD,
// frames 8-bit characters at /1, /16 or /64 and holds one character behind a valid/ready handshake.
module acia_rx_framer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxC,
    input  logic       RxD,
    input  logic       DCD,
    input  logic [1:0] cfg_div,
    input  logic [1:0] cfg_parity,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_fe,
    output logic       rx_pe,
    output logic       ovr,
    output logic       dcd_lost,
    input  logic       status_clr
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] rxc_sync_reg, rxd_sync_reg, dcd_sync_reg;
    logic [SYNC_STAGES-1:0] rxc_sync_next, rxd_sync_next, dcd_sync_next;
    logic                   rxc_prev_reg, dcd_prev_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign rxc_sync_next[gi] = RxC;
                assign rxd_sync_next[gi] = RxD;
                assign dcd_sync_next[gi] = DCD;
            end else begin : g_rest
                assign rxc_sync_next[gi] = rxc_sync_reg[gi-1];
                assign rxd_sync_next[gi] = rxd_sync_reg[gi-1];
                assign dcd_sync_next[gi] = dcd_sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            rxc_sync_reg <= '0;
            rxd_sync_reg <= '0;
            dcd_sync_reg <= '0;
            rxc_prev_reg <= 1'b0;
            dcd_prev_reg <= 1'b0;
        end else begin
            rxc_sync_reg <= rxc_sync_next;
            rxd_sync_reg <= rxd_sync_next;
            dcd_sync_reg <= dcd_sync_next;
            rxc_prev_reg <= rxc_sync_reg[SYNC_STAGES-1];
            dcd_prev_reg <= dcd_sync_reg[SYNC_STAGES-1];
        end
    end

    logic rxc_s, rxd_s, dcd_s, tick, dcd_rise;
    assign rxc_s    = rxc_sync_reg[SYNC_STAGES-1];
    assign rxd_s    = rxd_sync_reg[SYNC_STAGES-1];
    assign dcd_s    = dcd_sync_reg[SYNC_STAGES-1];
    assign tick     = rxc_s & ~rxc_prev_reg;
    assign dcd_rise = dcd_s & ~dcd_prev_reg;

    // ------------------------------------------------------------------
    // Framing state and datapath registers
    // ------------------------------------------------------------------
    state_t      state_reg, state_next;
    logic [5:0]  cnt_reg, cnt_next;
    logic [2:0]  bit_reg, bit_next;
    logic [7:0]  shift_reg, shift_next;
    logic [1:0]  div_reg, div_next;
    logic [1:0]  par_reg, par_next;
    logic        pe_reg, pe_next;

    logic [5:0]  last_cnt;
    logic [5:0]  start_cnt;
    logic        cnt_done;
    logic        par_en;

    // last_cnt is N-1; start_cnt is the pre-increment count at which the
    // start bit is re-checked, so the idle tick plus START spans N/2 ticks.
    always_comb begin
        last_cnt  = 6'd63;
        start_cnt = 6'd30;
        case (div_reg)
            2'b00: begin
                last_cnt  = 6'd0;
                start_cnt = 6'd0;
            end
            2'b01: begin
                last_cnt  = 6'd15;
                start_cnt = 6'd6;
            end
            default: begin
                last_cnt  = 6'd63;
                start_cnt = 6'd30;
            end
        endcase
    end

    assign cnt_done = (cnt_reg == last_cnt);
    assign par_en   = par_reg[1];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; carrier presence overrides everything else
    always_comb begin
        state_next = state_reg;
        if (dcd_s) begin
            state_next = S_IDLE;
        end else if (tick) begin
            case (state_reg)
                S_IDLE: begin
                    if (!rxd_s) begin
                        state_next = (cfg_div == 2'b00) ? S_DATA : S_START;
                    end
                end
                S_START: begin
                    if (cnt_reg == start_cnt) begin
                        state_next = rxd_s ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (cnt_done && bit_reg == 3'd7) begin
                        state_next = par_en ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (cnt_done) begin
                        state_next = S_STOP;
                    end
                end
                S_STOP: begin
                    if (cnt_done) begin
                        state_next = rxd_s ? S_IDLE : S_WAIT_HIGH;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rxd_s) begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // State outputs: counter, shifter, parity and the holding-register load strobe
    logic load, load_fe, load_pe;

    always_comb begin
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        div_next   = div_reg;
        par_next   = par_reg;
        pe_next    = pe_reg;
        load       = 1'b0;
        load_fe    = 1'b0;
        load_pe    = par_en & pe_reg;
        if (dcd_s) begin
            cnt_next = 6'd0;
            bit_next = 3'd0;
        end else if (tick) begin
            case (state_reg)
                S_IDLE: begin
                    if (!rxd_s) begin
                        div_next = cfg_div;
                        par_next = cfg_parity;
                        cnt_next = 6'd0;
                        bit_next = 3'd0;
                        pe_next  = 1'b0;
                    end
                end
                S_START: begin
                    cnt_next = (cnt_reg == start_cnt) ? 6'd0 : cnt_reg + 6'd1;
                end
                S_DATA: begin
                    if (cnt_done) begin
                        shift_next = {rxd_s, shift_reg[7:1]};
                        bit_next   = bit_reg + 3'd1;
                        cnt_next   = 6'd0;
                    end else begin
                        cnt_next = cnt_reg + 6'd1;
                    end
                end
                S_PARITY: begin
                    if (cnt_done) begin
                        pe_next  = ((^shift_reg) ^ rxd_s) != par_reg[0];
                        cnt_next = 6'd0;
                    end else begin
                        cnt_next = cnt_reg + 6'd1;
                    end
                end
                S_STOP: begin
                    if (cnt_done) begin
                        load     = 1'b1;
                        load_fe  = ~rxd_s;
                        cnt_next = 6'd0;
                    end else begin
                        cnt_next = cnt_reg + 6'd1;
                    end
                end
                default: begin
                    cnt_next = 6'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg   <= 6'd0;
            bit_reg   <= 3'd0;
            shift_reg <= 8'h00;
            div_reg   <= 2'b00;
            par_reg   <= 2'b00;
            pe_reg    <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            div_reg   <= div_next;
            par_reg   <= par_next;
            pe_reg    <= pe_next;
        end
    end

    // ------------------------------------------------------------------
    // Holding register and sticky status
    // ------------------------------------------------------------------
    logic consume, accept;
    assign consume = rx_valid & rx_ready;
    assign accept  = load & (~rx_valid | rx_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            rx_fe    <= 1'b0;
            rx_pe    <= 1'b0;
        end else if (accept) begin
            rx_data  <= shift_reg;
            rx_valid <= 1'b1;
            rx_fe    <= load_fe;
            rx_pe    <= load_pe;
        end else if (consume) begin
            rx_valid <= 1'b0;
        end
    end

    // A set in the same cycle as status_clr wins so no event is lost
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr      <= 1'b0;
            dcd_lost <= 1'b0;
        end else begin
            if (load && !accept) begin
                ovr <= 1'b1;
            end else if (status_clr) begin
                ovr <= 1'b0;
            end
            if (dcd_rise) begin
                dcd_lost <= 1'b1;
            end else if (status_clr) begin
                dcd_lost <= 1'b0;
            end
        end
    end

endmodule

// File: doc/acia_rx_framer.md
# acia_rx_framer

Receive framer that consumes the serial ULA's ACIA-side outputs (RxC, RxD, DCD) and assembles 8-bit asynchronous characters for the host bus. It takes the place of the 6850's receive path in the FPGA build. It samples RxD on rising edges of RxC at ÷1, ÷16 or ÷64, checks parity and stop bit, and holds one character in a handshaked holding register. Overrun and carrier-loss are reported as sticky status.

## Interface
- SYNC_STAGES, 2, synchroniser depth applied to RxC, RxD and DCD (≥2).
- clk  in  1  system clock (16/13 MHz); all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- RxC  in  1  receive clock from serial ULA (tape-recovered or baud-rate).
- RxD  in  1  receive data from serial ULA.
- DCD  in  1  carrier detect from serial ULA; high inhibits the receiver.
- cfg_div  in  2  00=÷1, 01=÷16, 10=÷64, 11=÷64.
- cfg_parity  in  2  0x=none, 10=even, 11=odd.
- rx_data  out  8  received character, LSB = first data bit.
- rx_valid  out  1  holding register full.
- rx_ready  in  1  consumer accepts rx_data when rx_valid & rx_ready.
- rx_fe  out  1  framing error for the held character.
- rx_pe  out  1  parity error for the held character (0 when parity is off).
- ovr  out  1  sticky overrun.
- dcd_lost  out  1  sticky; set on DCD rising edge.
- status_clr  in  1  single-cycle pulse; clears ovr and dcd_lost.

## Operation
- Synchronisers: RxC, RxD and DCD each pass through SYNC_STAGES flops. tick = synchronised RxC rising edge (one clk wide). Every RxD sample uses the synchronised RxD from the same stage as RxC.
- N = 1/16/64 from cfg_div. cfg_div and cfg_parity are latched on the IDLE exit transition. Changes mid-frame do not affect the current frame.
- 6-bit tick counter cnt; 3-bit bit index; 8-bit shift register, LSB first.
- States IDLE, START, DATA, PARITY, STOP, WAIT_HIGH. All transitions occur only on tick except DCD abort.
- IDLE: on a tick with rxd=0, go to DATA if N=1 (start bit taken as sampled) or START with cnt=0 otherwise.
- START: cnt++ each tick. When cnt reaches N/2−1:
  - rxd=1 → IDLE (false start, no flags).
  - rxd=0 → DATA, cnt=0.
- DATA: cnt++ each tick. At cnt=N−1, sample rxd into the shift register and set cnt=0. After the 8th sample go to PARITY if parity is enabled, else STOP.
- PARITY: sample at cnt=N−1. pe = (XOR of data ^ parity bit) ≠ expected; expected is 0 for even, 1 for odd.
- STOP: sample at cnt=N−1 and load the holding register.
  - Stop=1 → IDLE, fe=0.
  - Stop=0 → WAIT_HIGH, fe=1. WAIT_HIGH goes to IDLE on the first tick with rxd=1, so a break produces exactly one 0x00 character.
- Holding register load (at the STOP sample):
  - Register empty, or being consumed this cycle: load rx_data, rx_fe, rx_pe and set rx_valid=1.
  - Register full and not consumed: discard the new character, keep the old one, set ovr.
- rx_valid clears on a cycle with rx_valid & rx_ready, unless a load occurs in the same cycle. In that case it stays 1 with the new data.
- DCD: while synchronised DCD=1, the FSM is forced to IDLE, cnt=0, and any partial character is discarded. The holding register is unaffected. A DCD 0→1 edge sets dcd_lost.
- Sticky flags: set has priority over a simultaneous status_clr.

## Timing
- Reset values:
  - rx_data=0x00, rx_valid=0, rx_fe=0, rx_pe=0, ovr=0, dcd_lost=0.
  - FSM=IDLE, cnt=0, synchronisers=0.
- Reset is honoured mid-frame and discards the partial character.
- Input latency: RxC rising between posedges c−1 and c is captured at posedge c. tick is high in the cycle after posedge c+SYNC_STAGES−1. This is 2 cycles for the default.
- rx_valid, rx_data and the flags update at the clk edge ending the tick cycle of the stop sample.
- ÷1 frame: 10 ticks (8N1) or 11 ticks (8P1) from the start tick to the load.
- ÷16 frame: 8+16·9 ticks (8N1) from the first low tick to the load. ÷64 frame: 32+64·9 ticks.
- Throughput: one character per frame. The consumer has one full frame to read before an overrun occurs.
- RxC high and low times must each be ≥ SYNC_STAGES+1 clk cycles. Narrower pulses may be missed, and this is not checked.

## Test plan
- ÷1, parity none: send 0xA5 as 8N1, one bit per RxC pulse, rx_ready=1 → one rx_valid pulse with rx_data=0xA5, fe=0, pe=0.
- ÷16, parity odd: send 0x3C with a correct parity bit, then 0x3C with a flipped parity bit → rx_pe=0 then rx_pe=1. Separately, a start glitch 4 ticks long → no character.
- ÷64, rx_ready=0: send 0x11 then 0x22 → rx_data stays 0x11 and ovr=1. Assert rx_ready in the same cycle as the 0x33 load → rx_data=0x33 and rx_valid stays 1.
- Break: hold RxD=0 for 30 ticks at ÷1 → exactly one character 0x00 with fe=1. The next frame after RxD returns high decodes correctly.
- Raise DCD mid-character at ÷16 → no character, dcd_lost=1. status_clr → dcd_lost=0. A status_clr coincident with a new DCD edge leaves dcd_lost=1.
- Assert reset during DATA → all outputs return to their reset values. The next 0x5A frame decodes correctly.
